// File: rtl/frame_buf_pkg.sv
// Shared encodings for the frame-buffer arbiter: enable polarities, FSM states
// and the grant identifiers used for round-robin bookkeeping.
package frame_buf_pkg;

  localparam logic ASSERT_L   = 1'b0;
  localparam logic DEASSERT_L = 1'b1;
  localparam logic ASSERT_H   = 1'b1;
  localparam logic DEASSERT_H = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITE     = 2'd1,
    ST_READ      = 2'd2,
    ST_READ_WAIT = 2'd3
  } state_t;

  typedef enum logic {
    GNT_WR = 1'b0,
    GNT_RD = 1'b1
  } grant_t;

endpackage

// File: rtl/frame_addr_ctr.sv
// Sequential frame address counter: 0..FRAME_PIXELS-1, wraps to 0 and
// emits a registered one-cycle wrap pulse on the increment that wraps.
module frame_addr_ctr
  import frame_buf_pkg::*;
#(
  parameter int ADDR_WIDTH   = 29,
  parameter int FRAME_PIXELS = 307200
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_inc,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic                  o_wrap
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FRAME_PIXELS - 1);

  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_wrap;
  logic                  w_at_last;

  assign w_at_last = (r_addr == LAST_ADDR);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_addr <= '0;
      r_wrap <= DEASSERT_H;
    end else begin
      r_wrap <= (i_inc && w_at_last) ? ASSERT_H : DEASSERT_H;
      if (i_inc) begin
        r_addr <= w_at_last ? '0 : r_addr + ADDR_WIDTH'(1);
      end
    end
  end

  assign o_addr = r_addr;
  assign o_wrap = r_wrap;

endmodule

// File: rtl/frame_buf_arb.sv
// Single-port frame-buffer arbiter: round-robins a pixel write stream and a
// pixel read stream onto one memory, one command in flight, registered outputs.
module frame_buf_arb
  import frame_buf_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 29,
  parameter int FRAME_PIXELS = 307200,
  parameter int RD_LAT       = 2
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_wr_valid,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  output logic                  o_wr_ready,
  input  logic                  i_rd_req,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic                  o_rd_valid,
  output logic                  o_wr_frame_done,
  output logic                  o_rd_frame_done,
  output logic                  o_mem_wr_en,
  output logic                  o_mem_rd_en,
  output logic [ADDR_WIDTH-1:0] o_mem_wr_addr,
  output logic [ADDR_WIDTH-1:0] o_mem_rd_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wr_data,
  input  logic [DATA_WIDTH-1:0] i_mem_rd_data
);

  localparam int                LAT_W    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [LAT_W-1:0]  LAT_INIT = LAT_W'(RD_LAT - 1);

  state_t                r_state, w_state_nxt;
  grant_t                r_last_grant, w_grant_nxt;
  logic [LAT_W-1:0]      r_lat_cnt, w_lat_nxt;
  logic                  w_wr_inc, w_rd_inc;
  logic [ADDR_WIDTH-1:0] w_wr_ptr, w_rd_ptr;

  logic                  r_mem_wr_en, r_mem_rd_en;
  logic [ADDR_WIDTH-1:0] r_mem_wr_addr, r_mem_rd_addr;
  logic [DATA_WIDTH-1:0] r_mem_wr_data, r_rd_data;
  logic                  r_wr_ready, r_rd_valid;

  frame_addr_ctr #(.ADDR_WIDTH(ADDR_WIDTH), .FRAME_PIXELS(FRAME_PIXELS)) u_wr_ptr (
    .i_clk (i_clk), .i_reset (i_reset), .i_inc (w_wr_inc),
    .o_addr(w_wr_ptr), .o_wrap (o_wr_frame_done)
  );

  frame_addr_ctr #(.ADDR_WIDTH(ADDR_WIDTH), .FRAME_PIXELS(FRAME_PIXELS)) u_rd_ptr (
    .i_clk (i_clk), .i_reset (i_reset), .i_inc (w_rd_inc),
    .o_addr(w_rd_ptr), .o_wrap (o_rd_frame_done)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_last_grant;
    w_lat_nxt   = r_lat_cnt;
    w_wr_inc    = 1'b0;
    w_rd_inc    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // Contention goes to whichever side did not win last time.
        if (i_wr_valid && i_rd_req) begin
          w_state_nxt = (r_last_grant == GNT_RD) ? ST_WRITE : ST_READ;
          w_grant_nxt = (r_last_grant == GNT_RD) ? GNT_WR : GNT_RD;
        end else if (i_wr_valid) begin
          w_state_nxt = ST_WRITE;
          w_grant_nxt = GNT_WR;
        end else if (i_rd_req) begin
          w_state_nxt = ST_READ;
          w_grant_nxt = GNT_RD;
        end
      end
      ST_WRITE: begin
        w_state_nxt = ST_IDLE;
        w_wr_inc    = 1'b1;
      end
      ST_READ: begin
        w_state_nxt = ST_READ_WAIT;
        w_lat_nxt   = LAT_INIT;
      end
      default: begin
        if (r_lat_cnt == '0) begin
          w_state_nxt = ST_IDLE;
          w_rd_inc    = 1'b1;
        end else begin
          w_lat_nxt = r_lat_cnt - LAT_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state       <= ST_IDLE;
      r_last_grant  <= GNT_RD;
      r_lat_cnt     <= '0;
      r_mem_wr_en   <= DEASSERT_L;
      r_mem_rd_en   <= DEASSERT_L;
      r_mem_wr_addr <= '0;
      r_mem_rd_addr <= '0;
      r_mem_wr_data <= '0;
      r_rd_data     <= '0;
      r_wr_ready    <= DEASSERT_H;
      r_rd_valid    <= DEASSERT_H;
    end else begin
      r_state      <= w_state_nxt;
      r_last_grant <= w_grant_nxt;
      r_lat_cnt    <= w_lat_nxt;
      r_mem_wr_en  <= (w_state_nxt == ST_WRITE) ? ASSERT_L : DEASSERT_L;
      r_mem_rd_en  <= (w_state_nxt == ST_READ)  ? ASSERT_L : DEASSERT_L;
      r_wr_ready   <= (w_state_nxt == ST_WRITE) ? ASSERT_H : DEASSERT_H;
      r_rd_valid   <= w_rd_inc ? ASSERT_H : DEASSERT_H;
      if (r_state == ST_IDLE && w_state_nxt == ST_WRITE) begin
        r_mem_wr_data <= i_wr_data;
        r_mem_wr_addr <= w_wr_ptr;
      end
      if (r_state == ST_IDLE && w_state_nxt == ST_READ) begin
        r_mem_rd_addr <= w_rd_ptr;
      end
      if (w_rd_inc) begin
        r_rd_data <= i_mem_rd_data;
      end
    end
  end

  assign o_mem_wr_en   = r_mem_wr_en;
  assign o_mem_rd_en   = r_mem_rd_en;
  assign o_mem_wr_addr = r_mem_wr_addr;
  assign o_mem_rd_addr = r_mem_rd_addr;
  assign o_mem_wr_data = r_mem_wr_data;
  assign o_rd_data     = r_rd_data;
  assign o_wr_ready    = r_wr_ready;
  assign o_rd_valid    = r_rd_valid;

endmodule
